// File: rtl/key_repeat_if.sv
// rtl/key_repeat_if.sv - key input and move-pulse bundle for key_repeat
interface key_repeat_if;
  logic       i_frame_tick;
  logic [7:0] i_keycode;
  logic       o_mv_left;
  logic       o_mv_right;
  logic       o_mv_down;
  logic       o_rot;
  logic       o_hard_drop;
  logic       o_active;

  // Keyboard/frame side: drives keycode and frame tick, observes the pulses
  modport master (
    output i_frame_tick,
    output i_keycode,
    input  o_mv_left,
    input  o_mv_right,
    input  o_mv_down,
    input  o_rot,
    input  o_hard_drop,
    input  o_active
  );

  // Repeater side
  modport slave (
    input  i_frame_tick,
    input  i_keycode,
    output o_mv_left,
    output o_mv_right,
    output o_mv_down,
    output o_rot,
    output o_hard_drop,
    output o_active
  );
endinterface

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - keyboard auto-repeat (DAS/ARR) to one-cycle move pulses
module key_repeat #(
  // Frame ticks from first press to first auto-repeat, legal 1..63
  parameter int DAS_FRAMES = 16,
  // Frame ticks between auto-repeats, legal 1..63
  parameter int ARR_FRAMES = 6
) (
  input  logic        i_clk,
  input  logic        i_reset,
  key_repeat_if.slave bus
);

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_ROT   = 8'h1A;
  localparam logic [7:0] KEY_HARD  = 8'h2C;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  // Thresholds as counter-width constants; the counter only ever counts
  // up to one of these, so it never needs to wrap.
  localparam logic [5:0] DAS_CNT = 6'(DAS_FRAMES);
  localparam logic [5:0] ARR_CNT = 6'(ARR_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_last_key;
  logic [7:0] w_last_key_nxt;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_nxt;
  logic [5:0] w_cnt_inc;

  logic       w_is_repeating;
  logic       w_is_once;
  logic       w_is_recognized;
  logic       w_key_changed;

  logic       w_fire;
  logic [7:0] w_fire_key;

  logic       r_mv_left;
  logic       r_mv_right;
  logic       r_mv_down;
  logic       r_rot;
  logic       r_hard_drop;
  logic       r_active;

  // Classify the current keycode and compare it with the held key
  always_comb begin
    w_is_repeating  = (bus.i_keycode == KEY_LEFT) ||
                      (bus.i_keycode == KEY_RIGHT) ||
                      (bus.i_keycode == KEY_DOWN);
    w_is_once       = (bus.i_keycode == KEY_ROT) ||
                      (bus.i_keycode == KEY_HARD);
    w_is_recognized = w_is_repeating || w_is_once;
    w_key_changed   = (bus.i_keycode != r_last_key);
    w_cnt_inc       = r_cnt + 6'd1;
  end

  // Next-state, held-key, frame counter and pulse-request decision
  always_comb begin
    w_state_nxt    = r_state;
    w_last_key_nxt = r_last_key;
    w_cnt_nxt      = r_cnt;
    w_fire         = 1'b0;
    w_fire_key     = KEY_NONE;

    // In IDLE last_key is 8'h00, so any recognized key counts as a change.
    // A change always wins over a coincident frame tick: the tick is dropped
    // and the counter restarts from zero.
    if ((r_state == IDLE) || w_key_changed) begin
      if (w_is_recognized) begin
        w_fire         = 1'b1;
        w_fire_key     = bus.i_keycode;
        w_last_key_nxt = bus.i_keycode;
        w_cnt_nxt      = 6'd0;
        w_state_nxt    = w_is_repeating ? DELAY : LOCK;
      end else begin
        w_last_key_nxt = KEY_NONE;
        w_cnt_nxt      = 6'd0;
        w_state_nxt    = IDLE;
      end
    end else begin
      case (r_state)
        DELAY: begin
          if (bus.i_frame_tick) begin
            if (w_cnt_inc == DAS_CNT) begin
              w_fire      = 1'b1;
              w_fire_key  = r_last_key;
              w_cnt_nxt   = 6'd0;
              w_state_nxt = REPEAT;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        REPEAT: begin
          if (bus.i_frame_tick) begin
            if (w_cnt_inc == ARR_CNT) begin
              w_fire     = 1'b1;
              w_fire_key = r_last_key;
              w_cnt_nxt  = 6'd0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        default: begin
          // LOCK holds rot/hard_drop without repeating; counter frozen
        end
      endcase
    end
  end

  // State, held key and frame counter registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_last_key <= KEY_NONE;
      r_cnt      <= 6'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_key <= w_last_key_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Registered one-hot move pulses and the active flag
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mv_left   <= 1'b0;
      r_mv_right  <= 1'b0;
      r_mv_down   <= 1'b0;
      r_rot       <= 1'b0;
      r_hard_drop <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_mv_left   <= w_fire && (w_fire_key == KEY_LEFT);
      r_mv_right  <= w_fire && (w_fire_key == KEY_RIGHT);
      r_mv_down   <= w_fire && (w_fire_key == KEY_DOWN);
      r_rot       <= w_fire && (w_fire_key == KEY_ROT);
      r_hard_drop <= w_fire && (w_fire_key == KEY_HARD);
      r_active    <= (w_state_nxt != IDLE);
    end
  end

  assign bus.o_mv_left   = r_mv_left;
  assign bus.o_mv_right  = r_mv_right;
  assign bus.o_mv_down   = r_mv_down;
  assign bus.o_rot       = r_rot;
  assign bus.o_hard_drop = r_hard_drop;
  assign bus.o_active    = r_active;

endmodule

// File: doc/key_repeat.md
KEY_REPEAT -- requirements
Module: key_repeat

Interface
REQ-001 The module SHALL have parameter DAS_FRAMES, default 16, giving the frame_ticks from first press to first auto-repeat (legal 1..63).
REQ-002 The module SHALL have parameter ARR_FRAMES, default 6, giving the frame_ticks between auto-repeats (legal 1..63).
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset, synchronous to Clk, active-high.
REQ-005 frame_tick  input  1  one-Clk-wide pulse, once per video frame.
REQ-006 keycode  input  8  current USB HID keycode; 8'h00 = no key.
REQ-007 mv_left  output  1  one-cycle pulse, move piece left (key 8'h04).
REQ-008 mv_right  output  1  one-cycle pulse, move piece right (key 8'h07).
REQ-009 mv_down  output  1  one-cycle pulse, soft drop (key 8'h16).
REQ-010 rot  output  1  one-cycle pulse, rotate piece (key 8'h1A).
REQ-011 hard_drop  output  1  one-cycle pulse, hard drop (key 8'h2C).
REQ-012 active  output  1  high whenever FSM is not in IDLE.

Function
REQ-013 Recognized keys: 8'h04, 8'h07, 8'h16 (repeating); 8'h1A, 8'h2C (non-repeating); any other value, including 8'h00, is "released".
REQ-014 FSM states SHALL be IDLE, DELAY, REPEAT, LOCK; registers last_key[7:0] and frame counter cnt[5:0].
REQ-015 All outputs SHALL be registered; a pulse appears exactly one Clk after the sampled condition causing it, and is high for exactly one Clk.
REQ-016 At most one of mv_left, mv_right, mv_down, rot, hard_drop SHALL be high in any cycle.
REQ-017 IDLE: released -> stay IDLE; recognized key K -> pulse K, last_key=K, cnt=0, go DELAY (repeating K) or LOCK (non-repeating K).
REQ-018 DELAY: keycode==last_key and frame_tick -> cnt+1; when incremented cnt equals DAS_FRAMES -> pulse last_key, cnt=0, go REPEAT.
REQ-019 REPEAT: keycode==last_key and frame_tick -> cnt+1; when incremented cnt equals ARR_FRAMES -> pulse last_key, cnt=0, stay REPEAT.
REQ-020 LOCK: keycode==last_key -> no pulses, cnt held; rot/hard_drop never auto-repeat.
REQ-021 In DELAY, REPEAT or LOCK, keycode!=last_key and released -> go IDLE, cnt=0, no pulse.
REQ-022 In DELAY, REPEAT or LOCK, keycode!=last_key and recognized K2 -> handled exactly as a new press from IDLE (pulse K2, cnt=0, state per REQ-017).
REQ-023 Key change and frame_tick in the same cycle: key change wins; frame_tick is discarded, cnt=0.
REQ-024 frame_tick with keycode stable and no threshold reached SHALL produce no pulse; cnt SHALL never exceed the active threshold and never wrap.
REQ-025 Same key released and re-pressed SHALL re-pulse immediately (IDLE re-entry requires one released sample).

Reset
REQ-026 Reset high at a rising edge SHALL force state=IDLE, last_key=8'h00, cnt=0, all outputs 0 on the next cycle, regardless of state or inputs.
REQ-027 Reset mid-hold: after Reset deasserts with keycode still held at a recognized K, the block SHALL treat K as a new press (pulse K one Clk later).
REQ-028 Outputs SHALL carry no pulse in the cycle following any Reset-asserted edge.

Verification
REQ-029 Reset, keycode=8'h1A held 100 frames -> exactly one rot pulse, one Clk after keycode first sampled; active stays 1.
REQ-030 Defaults, keycode=8'h04 held 40 frame_ticks -> mv_left pulses at press, after tick 16, 22, 28, 34, 40 (6 total).
REQ-031 keycode 8'h07 held 10 ticks then switched to 8'h16 on a frame_tick cycle -> immediate mv_down pulse, next mv_down after 16 further ticks; no extra mv_right.
REQ-032 keycode=8'h33 (unrecognized) for 50 ticks -> no pulses, active=0.
REQ-033 8'h04 held into REPEAT, Reset pulsed 1 cycle while held -> outputs 0 during reset, mv_left pulse one Clk after Reset deasserts, next after 16 ticks.
REQ-034 8'h2C pressed, 8'h00 one cycle, 8'h2C again -> two hard_drop pulses, one per press.
